// File: rtl/pitch_glide_ctrl_if.sv
// Note, register-write and key-output signals of the pitch glide controller.
// master drives notes/writes/tick, slave is the controller itself.
interface pitch_glide_ctrl_if #(
    parameter int V_WIDTH = 3,
    parameter int O_WIDTH = 2,
    parameter int FRAC_W  = 8
);
    logic                       tick;
    logic                       note_on;
    logic                       note_off;
    logic [V_WIDTH-1:0]         note_voice;
    logic [7:0]                 note_key;
    logic [13:0]                pitch_val;
    logic                       wr;
    logic [6:0]                 wr_adr;
    logic [7:0]                 wr_data;
    logic                       osc_sel;
    logic                       com_sel;
    logic                       busy;
    logic                       pitch_valid;
    logic [V_WIDTH+O_WIDTH-1:0] slot_idx;
    logic [8+FRAC_W:0]          pitch_key;

    modport master (
        output tick, note_on, note_off, note_voice, note_key, pitch_val,
        output wr, wr_adr, wr_data, osc_sel, com_sel,
        input  busy, pitch_valid, slot_idx, pitch_key
    );

    modport slave (
        input  tick, note_on, note_off, note_voice, note_key, pitch_val,
        input  wr, wr_adr, wr_data, osc_sel, com_sel,
        output busy, pitch_valid, slot_idx, pitch_key
    );
endinterface

// File: rtl/pitch_glide_ctrl.sv
// Per-voice portamento plus per-frame scan emitting a saturated fixed-point key index
// (offset +128 semitones) for every {voice, osc} slot through a 2-stage pipeline.
module pitch_glide_ctrl #(
    parameter int VOICES  = 8,
    parameter int V_WIDTH = 3,
    parameter int V_OSC   = 4,
    parameter int O_WIDTH = 2,
    parameter int FRAC_W  = 8
) (
    input logic               const_clk,
    input logic               iRST,
    pitch_glide_ctrl_if.slave bus
);
    localparam int KEY_W   = 9 + FRAC_W;
    localparam int CUR_W   = 8 + FRAC_W;
    localparam int S_W     = V_WIDTH + O_WIDTH;
    localparam int N_SLOT  = VOICES * V_OSC;
    localparam int BEND_SH = 13 - FRAC_W;
    localparam int KEY_MAX = (1 << KEY_W) - 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GLIDE = 2'd1;
    localparam logic [1:0] S_EMIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [7:0]         r_coarse [V_OSC];
    logic [7:0]         r_fine   [V_OSC];
    logic [7:0]         r_pb_range;
    logic [6:0]         r_glide_time;
    logic [1:0]         r_glide_mode;
    logic [CUR_W-1:0]   r_cur [VOICES];
    logic [CUR_W-1:0]   r_tgt [VOICES];
    logic [VOICES-1:0]  r_gate;

    logic [1:0]         r_state;
    logic [V_WIDTH-1:0] r_gv;
    logic [S_W-1:0]     r_slot;
    logic               r_drain;

    logic               r_s1_valid;
    logic [S_W-1:0]     r_s1_slot;
    logic signed [31:0] r_s1_sum;
    logic signed [31:0] r_s1_bend;
    logic               r_valid;
    logic [S_W-1:0]     r_slot_idx;
    logic [KEY_W-1:0]   r_key;

    // Register file
    logic w_osc_hit;
    assign w_osc_hit = (bus.wr_adr[3:1] == 3'd0) && (int'(bus.wr_adr[6:4]) < V_OSC);

    always_ff @(posedge const_clk or posedge iRST) begin
        if (iRST) begin
            for (int o = 0; o < V_OSC; o++) begin
                r_coarse[o] <= 8'h40;
                r_fine[o]   <= 8'h40;
            end
            r_pb_range   <= 8'd2;
            r_glide_time <= 7'd0;
            r_glide_mode <= 2'd0;
        end else if (bus.wr) begin
            if (bus.osc_sel) begin
                if (w_osc_hit) begin
                    if (bus.wr_adr[0]) r_fine[bus.wr_adr[4 +: O_WIDTH]]   <= bus.wr_data;
                    else               r_coarse[bus.wr_adr[4 +: O_WIDTH]] <= bus.wr_data;
                end
            end else if (bus.com_sel) begin
                case (bus.wr_adr)
                    7'd0:    r_pb_range   <= bus.wr_data;
                    7'd1:    r_glide_time <= bus.wr_data[6:0];
                    7'd2:    r_glide_mode <= bus.wr_data[1:0];
                    default: ;
                endcase
            end
        end
    end

    // Note handling and glide
    logic [CUR_W-1:0] w_note_tgt, w_g_cur, w_g_tgt, w_g_diff, w_step, w_g_next;
    logic             w_jump, w_g_up, w_note_hits_glide;

    assign w_note_tgt = {bus.note_key, {FRAC_W{1'b0}}};
    assign w_jump     = (r_glide_mode == 2'd0) || (r_glide_time == 7'd0) ||
                        ((r_glide_mode == 2'd2) && !r_gate[bus.note_voice]);
    assign w_note_hits_glide = bus.note_on && (bus.note_voice == r_gv);

    always_comb begin
        w_g_cur  = r_cur[r_gv];
        w_g_tgt  = r_tgt[r_gv];
        w_step   = CUR_W'(8'd128 - {1'b0, r_glide_time});
        w_g_up   = (w_g_tgt >= w_g_cur);
        w_g_diff = w_g_up ? (w_g_tgt - w_g_cur) : (w_g_cur - w_g_tgt);
        w_g_next = w_g_tgt;
        if (r_glide_time != 7'd0 && w_g_diff > w_step) begin
            w_g_next = w_g_up ? (w_g_cur + w_step) : (w_g_cur - w_step);
        end
    end

    always_ff @(posedge const_clk or posedge iRST) begin
        if (iRST) begin
            for (int v = 0; v < VOICES; v++) begin
                r_cur[v] <= CUR_W'(60 << FRAC_W);
                r_tgt[v] <= CUR_W'(60 << FRAC_W);
            end
            r_gate <= '0;
        end else begin
            if (r_state == S_GLIDE && !w_note_hits_glide) r_cur[r_gv] <= w_g_next;
            if (bus.note_on) begin
                r_tgt[bus.note_voice]  <= w_note_tgt;
                r_gate[bus.note_voice] <= 1'b1;
                if (w_jump) r_cur[bus.note_voice] <= w_note_tgt;
            end else if (bus.note_off) begin
                r_gate[bus.note_voice] <= 1'b0;
            end
        end
    end

    // Frame sequencer
    always_ff @(posedge const_clk or posedge iRST) begin
        if (iRST) begin
            r_state <= S_IDLE;
            r_gv    <= '0;
            r_slot  <= '0;
            r_drain <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.tick) begin
                        r_state <= S_GLIDE;
                        r_gv    <= '0;
                    end
                end
                S_GLIDE: begin
                    if (r_gv == V_WIDTH'(VOICES - 1)) begin
                        r_state <= S_EMIT;
                        r_slot  <= '0;
                    end else begin
                        r_gv <= r_gv + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (r_slot == S_W'(N_SLOT - 1)) begin
                        r_state <= S_DRAIN;
                        r_drain <= 1'b0;
                    end else begin
                        r_slot <= r_slot + 1'b1;
                    end
                end
                default: begin
                    if (r_drain) r_state <= S_IDLE;
                    r_drain <= 1'b1;
                end
            endcase
        end
    end

    // Datapath: stage 1 samples registers at issue, stage 2 adds offset and saturates
    logic [V_WIDTH-1:0] w_iv;
    logic [O_WIDTH-1:0] w_io;
    logic signed [31:0] w_base, w_bend_prod, w_sum;

    assign w_iv        = r_slot[O_WIDTH +: V_WIDTH];
    assign w_io        = r_slot[O_WIDTH-1:0];
    assign w_base      = int'(r_cur[w_iv]) +
                         (int'(r_coarse[w_io]) - 64) * (1 << FRAC_W) +
                         (int'(r_fine[w_io]) - 64) * (1 << (FRAC_W - 6));
    assign w_bend_prod = (int'(bus.pitch_val) - 8192) * int'(r_pb_range);
    assign w_sum       = r_s1_sum + r_s1_bend + (128 << FRAC_W);

    always_ff @(posedge const_clk or posedge iRST) begin
        if (iRST) begin
            r_s1_valid <= 1'b0;
            r_s1_slot  <= '0;
            r_s1_sum   <= '0;
            r_s1_bend  <= '0;
            r_valid    <= 1'b0;
            r_slot_idx <= '0;
            r_key      <= '0;
        end else begin
            r_s1_valid <= (r_state == S_EMIT);
            r_s1_slot  <= r_slot;
            r_s1_sum   <= w_base;
            r_s1_bend  <= w_bend_prod >>> BEND_SH;
            r_valid    <= r_s1_valid;
            if (r_s1_valid) begin
                r_slot_idx <= r_s1_slot;
                if (w_sum < 0)            r_key <= '0;
                else if (w_sum > KEY_MAX) r_key <= '1;
                else                      r_key <= w_sum[KEY_W-1:0];
            end
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.pitch_valid = r_valid;
    assign bus.slot_idx    = r_slot_idx;
    assign bus.pitch_key   = r_key;
endmodule

// File: tb/tb_pitch_glide_ctrl.sv
// Directed bench for pitch_glide_ctrl: vector table for the key-index sum plus
// sequences for frame timing, glide, legato, mid-frame writes and mid-frame reset.
module tb_pitch_glide_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pitch_glide_ctrl_if #(.V_WIDTH(3), .O_WIDTH(2), .FRAC_W(8)) pif ();

    pitch_glide_ctrl #(
        .VOICES(8), .V_WIDTH(3), .V_OSC(4), .O_WIDTH(2), .FRAC_W(8)
    ) dut (
        .const_clk(clk),
        .iRST     (rst),
        .bus      (pif.slave)
    );

    typedef struct {
        string       name;
        int          osc;
        logic [7:0]  coarse;
        logic [7:0]  fine;
        logic [7:0]  pb;
        logic [13:0] pv;
        int          voice;
        logic [7:0]  key;
        logic [16:0] exp_key;
    } vec_t;

    vec_t        vecs [7];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [16:0] cap_key [32];
    int          first_v, last_v, n_valid, drop_k, order_err;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr_reg(input logic osc, input logic com, input int adr, input logic [7:0] d);
        pif.wr = 1'b1; pif.osc_sel = osc; pif.com_sel = com;
        pif.wr_adr = 7'(adr); pif.wr_data = d;
        step();
        pif.wr = 1'b0; pif.osc_sel = 1'b0; pif.com_sel = 1'b0;
    endtask

    task automatic note(input logic on, input logic off, input int v, input logic [7:0] key);
        pif.note_on = on; pif.note_off = off; pif.note_voice = 3'(v); pif.note_key = key;
        step();
        pif.note_on = 1'b0; pif.note_off = 1'b0;
    endtask

    // Cycle k = k-th cycle after the tick cycle; optional extra tick and fine/coarse write
    task automatic run_frame(input int tick_at, input int wr_at, input int adr,
                             input logic [7:0] d);
        for (int i = 0; i < 32; i++) cap_key[i] = 'x;
        first_v = -1; last_v = -1; n_valid = 0; drop_k = -1; order_err = 0;
        pif.tick = 1'b1;
        step();
        pif.tick = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (pif.pitch_valid) begin
                if (first_v < 0) first_v = k;
                last_v = k;
                if (int'(pif.slot_idx) != n_valid) order_err++;
                cap_key[pif.slot_idx] = pif.pitch_key;
                n_valid++;
            end
            if (!pif.busy && drop_k < 0) drop_k = k;
            pif.tick    = (k == tick_at);
            pif.wr      = (k == wr_at);
            pif.osc_sel = (k == wr_at);
            pif.wr_adr  = 7'(adr);
            pif.wr_data = d;
            step();
        end
        pif.tick = 1'b0; pif.wr = 1'b0; pif.osc_sel = 1'b0;
    endtask

    task automatic check_timing(input string tag);
        check({tag, "_first_valid"}, first_v, 11);
        check({tag, "_last_valid"}, last_v, 42);
        check({tag, "_n_valid"}, n_valid, 32);
        check({tag, "_busy_drop"}, drop_k, 43);
        check({tag, "_slot_order"}, order_err, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        vecs[0] = '{"osc3_coarse_fine_bend", 3, 8'h4C, 8'h60, 8'd2,   14'h3FFF, 0, 8'd60,  17'hCA7F};
        vecs[1] = '{"osc0_bend_min",         0, 8'h40, 8'h40, 8'd2,   14'h0000, 1, 8'd72,  17'hC600};
        vecs[2] = '{"osc1_negative_offsets", 1, 8'h34, 8'h20, 8'd12,  14'h2000, 7, 8'd0,   17'h07380};
        vecs[3] = '{"sat_high",              2, 8'hFF, 8'h40, 8'hFF,  14'h3FFF, 3, 8'd127, 17'h1FFFF};
        vecs[4] = '{"sat_low",               0, 8'h00, 8'h40, 8'hFF,  14'h0000, 4, 8'd0,   17'h00000};
        vecs[5] = '{"coarse7f_key127",       1, 8'h7F, 8'h60, 8'd2,   14'h3FFF, 5, 8'd127, 17'h1407F};
        vecs[6] = '{"bend_minus_one_lsb",    3, 8'h40, 8'h40, 8'd2,   14'h1FFF, 6, 8'd64,  17'h0BFFF};

        pif.tick = 0; pif.note_on = 0; pif.note_off = 0; pif.note_voice = 0; pif.note_key = 0;
        pif.pitch_val = 14'h2000; pif.wr = 0; pif.wr_adr = 0; pif.wr_data = 0;
        pif.osc_sel = 0; pif.com_sel = 0;
        step();
        step();
        check("rst_busy", pif.busy, 0);
        check("rst_pitch_valid", pif.pitch_valid, 0);
        check("rst_slot_idx", pif.slot_idx, 0);
        check("rst_pitch_key", pif.pitch_key, 0);
        rst = 1'b0;
        step();

        // Default registers: every slot at (60+128)<<8, tick during DRAIN ignored
        run_frame(41, -1, 0, 8'h00);
        check_timing("default");
        for (int s = 0; s < 32; s++) check($sformatf("default_key_%0d", s), cap_key[s], 17'hBC00);

        // Write fine[0] while slot 12 is issuing: slot 12 old, later osc0 slots new
        run_frame(-1, 21, 7'h01, 8'h44);
        check_timing("midwrite");
        check("midwrite_slot0", cap_key[0], 17'hBC00);
        check("midwrite_slot12", cap_key[12], 17'hBC00);
        check("midwrite_slot16", cap_key[16], 17'hBC10);
        check("midwrite_slot28", cap_key[28], 17'hBC10);
        check("midwrite_slot13", cap_key[13], 17'hBC00);

        // Vector table, glide mode off so note_on jumps
        for (int i = 0; i < 7; i++) begin
            wr_reg(1, 0, (vecs[i].osc << 4), vecs[i].coarse);
            wr_reg(1, 0, (vecs[i].osc << 4) + 1, vecs[i].fine);
            wr_reg(0, 1, 0, vecs[i].pb);
            pif.pitch_val = vecs[i].pv;
            note(1, 0, vecs[i].voice, vecs[i].key);
            run_frame(-1, -1, 0, 8'h00);
            check(vecs[i].name, cap_key[vecs[i].voice * 4 + vecs[i].osc], vecs[i].exp_key);
        end
        pif.pitch_val = 14'h2000;

        // Glide always: 60 -> 62 at 16 LSB per frame
        do_reset();
        wr_reg(0, 1, 2, 8'd1);
        wr_reg(0, 1, 1, 8'h70);
        note(1, 0, 2, 8'd60);
        note(1, 0, 2, 8'd62);
        for (int n = 1; n <= 34; n++) begin
            run_frame(-1, -1, 0, 8'h00);
            if (n == 1 || n == 16 || n == 31 || n == 32 || n == 34)
                check($sformatf("glide_tick_%0d", n), cap_key[8],
                      17'hBC00 + 17'(16 * ((n > 32) ? 32 : n)));
        end
        check("glide_other_voice", cap_key[0], 17'hBC00);

        // Legato
        do_reset();
        wr_reg(0, 1, 2, 8'd2);
        wr_reg(0, 1, 1, 8'h70);
        note(1, 0, 1, 8'd72);
        run_frame(-1, -1, 0, 8'h00);
        check("legato_first_jump", cap_key[4], 17'hC800);
        note(1, 0, 1, 8'd74);
        run_frame(-1, -1, 0, 8'h00);
        check("legato_gated_glide", cap_key[4], 17'hC810);
        note(0, 1, 1, 8'd0);
        note(1, 0, 1, 8'd60);
        run_frame(-1, -1, 0, 8'h00);
        check("legato_regate_jump", cap_key[4], 17'hBC00);
        note(1, 1, 1, 8'd60);
        note(1, 0, 1, 8'd62);
        run_frame(-1, -1, 0, 8'h00);
        check("note_on_beats_off", cap_key[4], 17'hBC10);

        // Reset mid-EMIT
        wr_reg(1, 0, 7'h10, 8'h50);
        pif.tick = 1'b1;
        step();
        pif.tick = 1'b0;
        for (int k = 1; k < 20; k++) step();
        check("pre_rst_valid", pif.pitch_valid, 1);
        rst = 1'b1;
        #1;
        check("midrst_busy", pif.busy, 0);
        check("midrst_valid", pif.pitch_valid, 0);
        step();
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (pif.pitch_valid || pif.busy) cnt++;
        end
        check("post_rst_no_output", cnt, 0);
        run_frame(-1, -1, 0, 8'h00);
        check_timing("post_rst");
        check("post_rst_cur", cap_key[4], 17'hBC00);
        check("post_rst_coarse", cap_key[5], 17'hBC00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pitch_glide_ctrl.md
Name: pitch_glide_ctrl

Overview:
Parametrised, fully synchronous successor to the per-voice pitch front end. It holds a per-voice current pitch that glides (portamento) toward the last note's key once per frame, with glide modes off/always/legato. On each frame tick it scans every voice/oscillator slot and emits a fixed-point key index. The index combines oscillator coarse/fine offsets and scaled pitch bend, and feeds the downstream constant-map/phase-increment stage.

Parameters:
VOICES, 8, number of voices
V_WIDTH, 3, log2(VOICES)
V_OSC, 4, oscillators per voice
O_WIDTH, 2, log2(V_OSC)
FRAC_W, 8, fractional bits of key index (>=6)

Ports:
const_clk  in  1  system clock
iRST  in  1  asynchronous reset, active-high
tick  in  1  frame-start pulse
note_on  in  1  one-cycle note-on strobe
note_off  in  1  one-cycle note-off strobe
note_voice  in  V_WIDTH  voice addressed by note_on/note_off
note_key  in  8  MIDI key, 0..127
pitch_val  in  14  pitch bend, 0x2000 = centre
wr  in  1  register write strobe
wr_adr  in  7  register address
wr_data  in  8  register write data
osc_sel  in  1  selects oscillator register bank
com_sel  in  1  selects common register bank
busy  out  1  frame scan in progress
pitch_valid  out  1  pitch_key/slot_idx valid this cycle
slot_idx  out  V_WIDTH+O_WIDTH  {voice, osc} of output
pitch_key  out  9+FRAC_W  unsigned key index, offset +128 semitones

Behaviour:
- Registers are written on posedge const_clk when wr=1.
  - osc_sel: adr (o<<4)+0 sets coarse[o]; adr (o<<4)+1 sets fine[o].
  - com_sel: adr 0 sets pb_range, adr 1 sets glide_time (7 bit), adr 2 sets glide_mode (0 off, 1 always, 2 legato).
  - Other addresses are ignored. osc_sel has priority over com_sel.
- Reset values: coarse/fine=0x40, pb_range=2, glide_time=0, glide_mode=0, cur[v]=tgt[v]=60<<FRAC_W, gate[v]=0.
- Outputs at reset: busy=0, pitch_valid=0, slot_idx=0, pitch_key=0.
- Notes:
  - note_on: tgt[v]=key<<FRAC_W and gate[v]=1.
  - cur[v] jumps to tgt when glide_mode=0, glide_time=0, or glide_mode=2 with gate[v]=0 before the event. Otherwise cur[v] is unchanged.
  - note_off: gate[v]=0.
  - note_on and note_off in the same cycle: note_on wins.
- FSM IDLE -> GLIDE -> EMIT -> DRAIN -> IDLE.
  - IDLE: tick moves to GLIDE, busy=1 the next cycle. A tick while not IDLE is ignored.
  - GLIDE: one cycle per voice, v=0..VOICES-1.
    - Step = 128-glide_time, in LSBs.
    - If |tgt-cur| <= step then cur=tgt; otherwise cur moves toward tgt by step.
    - glide_time=0 implies cur=tgt.
    - A note_on to the voice being updated in the same cycle overrides the glide write.
  - EMIT: issues slots in order voice-major, osc-minor, one per cycle, VOICES*V_OSC cycles.
  - DRAIN: 2 cycles, then IDLE with busy=0 in the same cycle pitch_valid falls.
- Datapath: 2-stage pipeline. A slot issued at cycle t appears with pitch_valid=1 at t+2. pitch_valid is contiguous for VOICES*V_OSC cycles.
- Sum computed in signed arithmetic:
  - cur
  - + (coarse-64)<<FRAC_W
  - + (fine-64)<<(FRAC_W-6)
  - + ((pitch_val-0x2000)*pb_range)>>>(13-FRAC_W), arithmetic shift
  - + 128<<FRAC_W
- The sum saturates to [0, 2^(9+FRAC_W)-1].
- Register writes during EMIT take effect from the next slot issued. Values are sampled at issue.
- iRST mid-frame returns immediately to IDLE and all reset values; no partial output follows.

Test Plan:
- Reset, tick with default regs -> 32 valid cycles starting 2 cycles after the first EMIT cycle; every pitch_key = (60+128)<<8 = 0xBC00; busy drops after the last valid.
- glide_mode=1, glide_time=0x70, note_on v2 key 62 after v2 at 60 -> per tick cur[2] rises by 16 LSB; reaches 0x3E00 exactly after 32 ticks, then stays there with no overshoot.
- glide_mode=2: first note_on v1 key 72 -> jumps immediately; second note_on key 74 while gated -> glides; note_off then note_on 60 -> jumps.
- coarse[3]=0x4C, fine[3]=0x60, pitch_val=0x3FFF, pb_range=2 -> osc3 key = cur+12 semis+128 LSB+511 LSB (bend), saturation checked with coarse=0x7F, key 127.
- Tick during busy ignored; write to fine[0] mid-EMIT alters only slots issued after the write; iRST asserted mid-EMIT -> pitch_valid=0 and busy=0 immediately, cur back to 60<<8.
